// File: rtl/encoder_pkg.sv
// Shared encoder definitions: pin bit positions and the conditioning-stage state type.
package encoder_pkg;

    localparam int unsigned ENC_W = 3;
    localparam int unsigned ENC_Z = 2;
    localparam int unsigned ENC_A = 1;
    localparam int unsigned ENC_B = 0;

    typedef enum logic [0:0] {
        PRIME,
        RUN
    } enc_state_e;

endpackage

// File: rtl/encoder_input_filter_if.sv
// Encoder pin/bus bundle between the raw pin source and the conditioning stage.
interface encoder_input_filter_if #(
    parameter int unsigned ERR_W = 16
);
    import encoder_pkg::*;

    logic [ENC_W-1:0] enc_raw;
    logic [ENC_W-1:0] enc;
    logic             enc_chg;
    logic             err;
    logic [ERR_W-1:0] err_count;

    modport master (
        output enc_raw,
        input  enc,
        input  enc_chg,
        input  err,
        input  err_count
    );

    modport slave (
        input  enc_raw,
        output enc,
        output enc_chg,
        output err,
        output err_count
    );

endinterface

// File: rtl/input_glitch_filter.sv
// One encoder channel: synchroniser chain, stability counter and filtered bit.
// With en_i low the filtered bit tracks the synchronised value directly.
module input_glitch_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    input  logic en_i,
    output logic filt_o,
    output logic upd_o
);

    localparam int unsigned CNT_W = $clog2(FILT_CYCLES + 1);
    // Count value from which the next differing cycle would reach FILT_CYCLES.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   filt_q, filt_d;
    logic                   s;

    // Last chain stage is the synchronised value.
    assign s = sync_q[SYNC_STAGES-1];

    // Shift the raw pin into the chain; bit 0 is the first stage.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
    end

    // Stability filter: accept s once it has differed for FILT_CYCLES cycles.
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        upd_o  = 1'b0;
        if (!en_i) begin
            filt_d = s;
        end else if (s != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = s;
                upd_o  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Channel state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/encoder_input_filter.sv
// Encoder input conditioning: three filtered channels, priming FSM, change/error
// strobes and a saturating count of illegal A/B transitions.
module encoder_input_filter
    import encoder_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYCLES = 2,
    parameter int unsigned ERR_W       = 16
) (
    input logic                   clk,
    input logic                   rst,
    encoder_input_filter_if.slave bus
);

    localparam int unsigned PRIME_W = $clog2(SYNC_STAGES + FILT_CYCLES + 1);
    localparam logic [PRIME_W-1:0] PRIME_LOAD = PRIME_W'(SYNC_STAGES + FILT_CYCLES);
    localparam logic [PRIME_W-1:0] PRIME_ONE  = PRIME_W'(1);

    enc_state_e         state_q, state_d;
    logic [PRIME_W-1:0] prime_q, prime_d;
    logic [ENC_W-1:0]   filt;
    logic [ENC_W-1:0]   upd;
    logic               run;
    logic               enc_chg_q, enc_chg_d;
    logic               err_q, err_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;

    assign run = (state_q == RUN);

    for (genvar i = 0; i < ENC_W; i++) begin : g_chan
        input_glitch_filter #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILT_CYCLES(FILT_CYCLES)
        ) u_filt (
            .clk   (clk),
            .rst   (rst),
            .raw_i (bus.enc_raw[i]),
            .en_i  (run),
            .filt_o(filt[i]),
            .upd_o (upd[i])
        );
    end

    // Priming FSM: stay in PRIME until the sync chains and filters hold real data.
    always_comb begin
        state_d = state_q;
        prime_d = prime_q;
        unique case (state_q)
            PRIME: begin
                if (prime_q != '0) begin
                    prime_d = prime_q - 1'b1;
                end
                if (prime_q <= PRIME_ONE) begin
                    state_d = RUN;
                end
            end
            default: ;
        endcase
    end

    // Strobes and error count; upd is already suppressed outside RUN.
    always_comb begin
        enc_chg_d   = |upd;
        err_d       = upd[ENC_A] & upd[ENC_B];
        err_count_d = err_count_q;
        if (err_d && (err_count_q != '1)) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    // State, strobe and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PRIME;
            prime_q     <= PRIME_LOAD;
            enc_chg_q   <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            prime_q     <= prime_d;
            enc_chg_q   <= enc_chg_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.enc       = filt;
    assign bus.enc_chg   = enc_chg_q;
    assign bus.err       = err_q;
    assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_encoder_input_filter.sv
// Bench for encoder_input_filter: directed and random pin sequences checked every
// cycle against a cycle-level behavioural model, plus directed scenario checks.
module tb_encoder_input_filter;
    import encoder_pkg::*;

    localparam int unsigned SS = 2;
    localparam int unsigned FC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] raw = 3'b000;

    always #5 clk = ~clk;

    encoder_input_filter_if #(.ERR_W(16)) bus ();
    encoder_input_filter_if #(.ERR_W(4))  bus4 ();

    assign bus.enc_raw  = raw;
    assign bus4.enc_raw = raw;

    encoder_input_filter #(
        .SYNC_STAGES(SS),
        .FILT_CYCLES(FC),
        .ERR_W      (16)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    encoder_input_filter #(
        .SYNC_STAGES(SS),
        .FILT_CYCLES(FC),
        .ERR_W      (4)
    ) u_dut4 (
        .clk(clk),
        .rst(rst),
        .bus(bus4)
    );

    int tests = 0;
    int fails = 0;
    int chg_seen = 0;
    int err_seen = 0;
    int enc010_cycles = 0;

    // Behavioural model state.
    logic [2:0] m_sync [SS];
    int         m_diff [3];
    logic [2:0] m_enc;
    logic       m_chg;
    logic       m_err;
    int         m_cnt;
    int         m_cnt4;
    int         m_prime;
    bit         m_in_run;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge of the model, given the pin value and rst seen at that edge.
    task automatic model_step(input logic [2:0] r, input logic rr);
        logic [2:0] s;
        logic [2:0] flips;
        if (rr) begin
            for (int k = 0; k < SS; k++) m_sync[k] = 3'b000;
            for (int i = 0; i < 3; i++) m_diff[i] = 0;
            m_enc    = 3'b000;
            m_chg    = 1'b0;
            m_err    = 1'b0;
            m_cnt    = 0;
            m_cnt4   = 0;
            m_prime  = SS + FC;
            m_in_run = 1'b0;
        end else begin
            s     = m_sync[SS-1];
            flips = 3'b000;
            if (!m_in_run) begin
                m_enc = s;
                m_chg = 1'b0;
                m_err = 1'b0;
                for (int i = 0; i < 3; i++) m_diff[i] = 0;
                m_prime--;
                if (m_prime == 0) m_in_run = 1'b1;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (s[i] == m_enc[i]) begin
                        m_diff[i] = 0;
                    end else begin
                        m_diff[i]++;
                        if (m_diff[i] == FC) begin
                            m_diff[i] = 0;
                            flips[i]  = 1'b1;
                        end
                    end
                end
                m_enc = m_enc ^ flips;
                m_chg = |flips;
                m_err = flips[ENC_A] & flips[ENC_B];
                if (m_err) begin
                    if (m_cnt < 65535) m_cnt++;
                    if (m_cnt4 < 15) m_cnt4++;
                end
            end
            for (int k = SS - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
            m_sync[0] = r;
        end
    endtask

    task automatic tick();
        logic [2:0] r;
        logic       rr;
        @(posedge clk);
        r  = raw;
        rr = rst;
        #1;
        model_step(r, rr);
        chk("enc", 32'(bus.enc), 32'(m_enc));
        chk("enc_chg", 32'(bus.enc_chg), 32'(m_chg));
        chk("err", 32'(bus.err), 32'(m_err));
        chk("err_count", 32'(bus.err_count), 32'(m_cnt));
        chk("enc_w4", 32'(bus4.enc), 32'(m_enc));
        chk("err_count_w4", 32'(bus4.err_count), 32'(m_cnt4));
        if (bus.enc_chg) chg_seen++;
        if (bus.err) err_seen++;
        if (bus.enc == 3'b010) enc010_cycles++;
    endtask

    task automatic hold(input logic [2:0] v, input int n);
        raw = v;
        repeat (n) tick();
    endtask

    initial begin
        // Reset and prime with pins at 011.
        raw = 3'b011;
        rst = 1'b1;
        tick();
        chk("rst_enc", 32'(bus.enc), 32'd0);
        chk("rst_chg", 32'(bus.enc_chg), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_cnt", 32'(bus.err_count), 32'd0);
        rst = 1'b0;
        chg_seen = 0;
        err_seen = 0;
        repeat (4) tick();
        chk("prime_enc", 32'(bus.enc), 32'b011);
        chk("prime_no_chg", 32'(chg_seen), 32'd0);
        chk("prime_no_err", 32'(err_seen), 32'd0);
        chk("prime_cnt", 32'(bus.err_count), 32'd0);

        // Filter must be active now: a B drop lands 4 edges after first sample.
        hold(3'b010, 3);
        chk("lat_before", 32'(bus.enc), 32'b011);
        tick();
        chk("lat_after", 32'(bus.enc), 32'b010);
        chk("lat_chg", 32'(bus.enc_chg), 32'd1);
        hold(3'b000, 8);

        // Single-cycle glitch rejected, two-cycle pulse accepted.
        chg_seen = 0;
        hold(3'b010, 1);
        hold(3'b000, 8);
        chk("glitch_enc", 32'(bus.enc), 32'd0);
        chk("glitch_chg", 32'(chg_seen), 32'd0);
        chg_seen = 0;
        enc010_cycles = 0;
        hold(3'b010, 2);
        hold(3'b000, 8);
        chk("pulse2_cycles", 32'(enc010_cycles), 32'd2);
        chk("pulse2_chg", 32'(chg_seen), 32'd2);

        // Clockwise then counter-clockwise quadrature, 13 cycles each.
        chg_seen = 0;
        for (int n = 0; n < 13; n++) begin
            hold(3'b010, 3);
            hold(3'b011, 3);
            hold(3'b001, 3);
            hold(3'b000, 3);
        end
        hold(3'b000, 6);
        chk("cw_chg", 32'(chg_seen), 32'd52);
        chk("cw_errcnt", 32'(bus.err_count), 32'd0);
        chg_seen = 0;
        for (int n = 0; n < 13; n++) begin
            hold(3'b001, 3);
            hold(3'b011, 3);
            hold(3'b010, 3);
            hold(3'b000, 3);
        end
        hold(3'b000, 6);
        chk("ccw_chg", 32'(chg_seen), 32'd52);
        chk("ccw_errcnt", 32'(bus.err_count), 32'd0);

        // Illegal A/B jump, then Z with A (legal).
        chg_seen = 0;
        err_seen = 0;
        hold(3'b011, 5);
        chk("ill_enc", 32'(bus.enc), 32'b011);
        chk("ill_err", 32'(err_seen), 32'd1);
        chk("ill_chg", 32'(chg_seen), 32'd1);
        chk("ill_errcnt", 32'(bus.err_count), 32'd1);
        hold(3'b001, 4);
        hold(3'b000, 4);
        err_seen = 0;
        hold(3'b110, 5);
        chk("za_enc", 32'(bus.enc), 32'b110);
        hold(3'b100, 4);
        hold(3'b000, 4);
        chk("za_err", 32'(err_seen), 32'd0);
        chk("za_errcnt", 32'(bus.err_count), 32'd1);

        // Saturation of the 4-bit counter.
        err_seen = 0;
        for (int n = 0; n < 17; n++) hold((n % 2 == 0) ? 3'b011 : 3'b000, 3);
        hold(3'b011, 4);
        chk("sat_err", 32'(err_seen), 32'd17);
        chk("sat_cnt4", 32'(bus4.err_count), 32'd15);
        chk("sat_cnt16", 32'(bus.err_count), 32'd18);
        hold(3'b000, 5);
        chk("sat_hold4", 32'(bus4.err_count), 32'd15);
        chk("sat_err_more", 32'(err_seen), 32'd18);

        // Random pin activity with mixed hold lengths.
        for (int n = 0; n < 300; n++) begin
            hold(3'($urandom_range(0, 7)), int'($urandom_range(1, 4)));
        end
        hold(raw, 8);

        // Mid-run reset with a non-zero filter count and err_count = 5.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        hold(3'b000, 8);
        for (int n = 0; n < 5; n++) hold((n % 2 == 0) ? 3'b011 : 3'b000, 4);
        hold(3'b011, 2);
        chk("mid_errcnt5", 32'(bus.err_count), 32'd5);
        hold(3'b001, 3);
        rst = 1'b1;
        tick();
        chk("mid_rst_enc", 32'(bus.enc), 32'd0);
        chk("mid_rst_chg", 32'(bus.enc_chg), 32'd0);
        chk("mid_rst_err", 32'(bus.err), 32'd0);
        chk("mid_rst_cnt", 32'(bus.err_count), 32'd0);
        rst = 1'b0;
        repeat (4) tick();
        chk("mid_prime_enc", 32'(bus.enc), 32'b001);
        hold(3'b000, 3);
        chk("mid_run_before", 32'(bus.enc), 32'b001);
        tick();
        chk("mid_run_after", 32'(bus.enc), 32'b000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/encoder_input_filter.md
# encoder_input_filter

Input conditioning stage placed directly upstream of `encoder4sig`. It takes the raw asynchronous encoder pins {Z, A, B}, synchronises them into the `clk` domain, and rejects glitches with a per-channel stability filter. It drives a clean 3-bit `enc` bus with the same bit ordering that `encoder4sig` consumes. It also flags illegal quadrature transitions, where A and B change on the same filtered update, and counts them.

## Interface
- `SYNC_STAGES`, 2: flip-flop depth of the synchroniser chain per channel (legal range ≥ 2).
- `FILT_CYCLES`, 2: consecutive cycles a synchronised value must differ from `enc` before `enc` takes it (legal range ≥ 1).
- `ERR_W`, 16: width of the illegal-transition counter.
- `clk`  in  1: system clock (100 MHz nominal).
- `rst`  in  1: synchronous, active-high reset.
- `enc_raw`  in  3: raw pins. Bit 2 = Z (index), bit 1 = A, bit 0 = B. Asynchronous to `clk`.
- `enc`  out  3: filtered, synchronous encoder bus with the same bit order. Feeds `encoder4sig`.
- `enc_chg`  out  1: one-cycle strobe, high in the cycle `enc` has just changed.
- `err`  out  1: one-cycle strobe, high in the cycle A and B both changed on the same update.
- `err_count`  out  ERR_W: saturating count of `err` strobes since reset.

## Operation
- **Synchroniser:** per channel, a `SYNC_STAGES`-deep flop chain; the last stage is the synchronised value `s[i]`.
- **Filter:** each channel has a counter `cnt[i]`.
  - If `s[i]` equals `enc[i]`, `cnt[i]` clears to 0.
  - Otherwise it increments. On the edge where it would reach `FILT_CYCLES`, `enc[i]` loads `s[i]` and `cnt[i]` clears.
  - A pulse on `s[i]` shorter than `FILT_CYCLES` cycles is rejected.
- **State machine:** states are `PRIME` and `RUN`.
  - `rst` forces `PRIME` and loads a prime counter with `SYNC_STAGES + FILT_CYCLES`.
  - In `PRIME`:
    - `enc` loads `s` directly every cycle.
    - `enc_chg` and `err` are held at 0.
    - The prime counter decrements each cycle; at 0 the state goes to `RUN`.
  - In `RUN`, the filter is active.
- **Strobes and error count (`RUN` only):**
  - `enc_chg` = 1 in the cycle after any `enc` bit updates.
  - `err` = 1 when bit 1 and bit 0 update on the same edge. Z is excluded.
  - `err_count` increments on each `err` and saturates at 2^`ERR_W` − 1.
- **Simultaneous events:** Z updating together with A or B is legal. A and B updating together raises a single `err`.

## Timing
- **Reset values** (on the edge `rst` is sampled high): `enc` = 3'b000, `enc_chg` = 0, `err` = 0, `err_count` = 0. All sync flops and counters = 0, state = `PRIME`.
- **Reset mid-operation:** identical to the above. No partial strobes are emitted on the reset edge.
- **Latency in `RUN`:** a stable change on `enc_raw[i]` first sampled at edge k appears on `enc[i]` after edge k + `SYNC_STAGES` + `FILT_CYCLES` − 1. With defaults this is 3 edges after k, i.e. 4 edges counted from k inclusive.
- **Strobe timing:** `enc_chg` and `err` are registered with `enc` and are high for exactly the one cycle in which the new `enc` is first visible.
- **Throughput:** the minimum accepted phase hold is `FILT_CYCLES` cycles. Back-to-back accepted changes on different channels may produce `enc_chg` on consecutive cycles.
- **Counter width:** `cnt` is $clog2(`FILT_CYCLES` + 1) bits. The prime counter is $clog2(`SYNC_STAGES` + `FILT_CYCLES` + 1) bits.

## Structure
- **Shared package `encoder_pkg`:**
  - Bit-index constants `ENC_Z` = 2, `ENC_A` = 1, `ENC_B` = 0.
  - The state enum {`PRIME`, `RUN`}.
  - The same constants are used by `encoder4sig` and benches.
- **Sub-module `input_glitch_filter`:** one channel, containing the sync chain, stability counter and filtered bit. It has an `en` input and an `upd` strobe output. The top instantiates it three times and owns the FSM, strobes and `err_count`.

## Test plan
- **Reset and prime:** hold `enc_raw` = 3'b011, pulse `rst` for 1 cycle, release.
  - During `PRIME`: `enc` = 011 by cycle 2, with `err` = 0 and `enc_chg` = 0 throughout.
  - After 4 cycles the state is `RUN` and `err_count` = 0.
- **Glitch rejection:** from 000, drive A = 1 for exactly 1 cycle.
  - `enc` stays 000 and `enc_chg` never asserts.
  - A 2-cycle pulse is accepted: `enc` = 010 for 2 cycles, then 000.
- **Clockwise sequence:** A ↑, B ↑, A ↓, B ↓, each held 3 cycles (30 ns), repeated 13 times.
  - `enc` follows with a 3-edge lag and there are 52 `enc_chg` pulses.
  - `err_count` = 0.
  - Repeat counter-clockwise (B leads) with the same result.
- **Illegal transition:** from 000, set A and B to 1 on the same edge and hold 5 cycles.
  - `enc` goes to 011 on a single edge, `err` pulses once and `err_count` = 1.
  - Z and A together produce no error.
- **Saturation:** with `ERR_W` = 4, apply 17 illegal A/B toggles.
  - `err_count` = 15 and holds.
  - `err` still pulses on every event.
- **Mid-run reset:** assert `rst` while `cnt` is non-zero and `err_count` = 5.
  - Next edge: all outputs are at reset values and the state is `PRIME`.
  - Re-prime completes after 4 cycles.
